// File: rtl/timer_pkg.sv
// timer_pkg: shared counter width, counter type and configuration record for the timer block.
package timer_pkg;
    localparam int TIM_W = 16;
    typedef logic [TIM_W-1:0] tim_cnt_t;
    typedef struct packed {
        tim_cnt_t psc;
        tim_cnt_t arr;
    } tim_cfg_t;
endpackage

// File: rtl/timer_if.sv
// timer_if: datapath-to-timer configuration/control bus plus the timer status returned to the core.
interface timer_if;
    import timer_pkg::*;
    logic     psc_wr, arr_wr, tim_en, ug, irq_en, flag_clr;
    tim_cnt_t psc_in, arr_in;
    tim_cnt_t cnt_out;
    logic     uev, uif, irq;
    modport master (
        output psc_wr, psc_in, arr_wr, arr_in, tim_en, ug, irq_en, flag_clr,
        input  cnt_out, uev, uif, irq
    );
    modport slave (
        input  psc_wr, psc_in, arr_wr, arr_in, tim_en, ug, irq_en, flag_clr,
        output cnt_out, uev, uif, irq
    );
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by (psc_act+1); the prescale value is always buffered in psc_pre.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_en,
    input  logic     i_clear,
    input  logic     i_reload,
    input  logic     i_wr,
    input  tim_cnt_t i_din,
    output logic     o_tick
);
    tim_cnt_t r_cnt, r_act, r_pre;

    assign o_tick = i_en && !i_clear && (r_cnt == r_act);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_act <= '0;
            r_pre <= '0;
        end else begin
            if (i_clear)
                r_cnt <= '0;
            else if (i_en)
                r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
            if (i_reload)
                r_act <= r_pre;
            if (i_wr)
                r_pre <= i_din;
        end
    end
endmodule

// File: rtl/timer_unit.sv
// timer_unit: up-counting timer 0..ARR with prescaler, update-event pulse, sticky flag and masked irq.
// Define TIMER_ARR_PRELOAD_EN to buffer auto-reload writes until the next update event or ug.
module timer_unit
    import timer_pkg::*;
#(
    parameter tim_cnt_t ARR_RST = 16'hFFFF
) (
    input logic clk,
    input logic reset,
    timer_if.slave bus
);
    logic     w_tick, w_wrap, w_uev_evt, w_reload;
    tim_cnt_t r_cnt, r_arr_act;
    logic     r_uev, r_uif, r_irq;

    // A counter left above a shrunk ARR runs to all-ones and wraps there.
    assign w_wrap    = (r_cnt == r_arr_act) || (r_cnt == '1);
    assign w_uev_evt = w_tick && w_wrap && !bus.ug;
    assign w_reload  = bus.ug || w_uev_evt;

    timer_prescaler u_psc (
        .clk      (clk),
        .reset    (reset),
        .i_en     (bus.tim_en),
        .i_clear  (bus.ug),
        .i_reload (w_reload),
        .i_wr     (bus.psc_wr),
        .i_din    (bus.psc_in),
        .o_tick   (w_tick)
    );

`ifdef TIMER_ARR_PRELOAD_EN
    tim_cnt_t r_arr_pre;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arr_pre <= ARR_RST;
            r_arr_act <= ARR_RST;
        end else begin
            if (bus.arr_wr)
                r_arr_pre <= bus.arr_in;
            if (w_reload)
                r_arr_act <= r_arr_pre;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset)
            r_arr_act <= ARR_RST;
        else if (bus.arr_wr)
            r_arr_act <= bus.arr_in;
    end
`endif

    // uif is set from the registered pulse so a clear coinciding with a visible uev loses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_uev <= 1'b0;
            r_uif <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (bus.ug)
                r_cnt <= '0;
            else if (w_tick)
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_uev <= w_uev_evt;
            r_uif <= r_uev || (r_uif && !bus.flag_clr);
            r_irq <= r_uif && bus.irq_en;
        end
    end

    assign bus.cnt_out = r_cnt;
    assign bus.uev     = r_uev;
    assign bus.uif     = r_uif;
    assign bus.irq     = r_irq;
endmodule
